// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between the processor
// (port C) and the host loader/debug port (port H). Single accesses are
// arbitrated round-robin. H may hold a lock for a bounded burst. Memory
// commands are registered, and read data is returned with a per-port valid tag.

// Protocol properties of the arbiter, kept apart from the design logic.
module dmem_arbiter_chk #(
    parameter int CW        = 4,
    parameter int MAX_BURST = 8
) (
    input logic          clk,
    input logic          rst,
    input logic          c_req,
    input logic          h_req,
    input logic          c_gnt,
    input logic          h_gnt,
    input logic [CW-1:0] cnt
);

    a_gnt_onehot: assert property (@(posedge clk) disable iff (rst) !(c_gnt && h_gnt));
    a_c_gnt_req:  assert property (@(posedge clk) disable iff (rst) c_gnt |-> c_req);
    a_h_gnt_req:  assert property (@(posedge clk) disable iff (rst) h_gnt |-> h_req);
    a_cnt_bound:  assert property (@(posedge clk) disable iff (rst) int'(cnt) <= MAX_BURST);

endmodule

module dmem_arbiter #(
    parameter int AW        = 8,
    parameter int DW        = 16,
    parameter int MAX_BURST = 8,
    parameter int CPU_FIRST = 1
) (
    input  logic          clk,
    input  logic          rst,
    // processor port
    input  logic          c_req,
    input  logic          c_wr,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_gnt,
    output logic          c_rvalid,
    // host port
    input  logic          h_req,
    input  logic          h_wr,
    input  logic          h_lock,
    input  logic [AW-1:0] h_addr,
    input  logic [DW-1:0] h_wdata,
    output logic          h_gnt,
    output logic          h_rvalid,
    // shared read data
    output logic [DW-1:0] rdata,
    // memory side
    output logic [AW-1:0] D_addr,
    output logic          D_wr,
    output logic [DW-1:0] D_wdata,
    input  logic [DW-1:0] D_rdata,
    output logic [1:0]    State
);

    // FSM encoding, visible on the State port
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CPU   = 2'd1;
    localparam logic [1:0] ST_HOST  = 2'd2;
    localparam logic [1:0] ST_BURST = 2'd3;

    // burst counter must hold values 0..MAX_BURST
    localparam int            CW       = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_BURST);

    // priority pointer: which port wins the next contested round-robin cycle
    localparam logic PRIO_C   = 1'b0;
    localparam logic PRIO_H   = 1'b1;
    localparam logic PRIO_RST = (CPU_FIRST != 0) ? PRIO_C : PRIO_H;

    logic [1:0]    state_r;
    logic [1:0]    state_nxt_s;
    logic          prio_r;
    logic          prio_nxt_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;
    logic          burst_hold_s;
    logic          c_gnt_s;
    logic          h_gnt_s;

    logic [AW-1:0] d_addr_r;
    logic          d_wr_r;
    logic [DW-1:0] d_wdata_r;

    logic          c_rd_p1_r;
    logic          h_rd_p1_r;
    logic          c_rvalid_r;
    logic          h_rvalid_r;

    // Grant selection: a lone requester always wins. Under contention a live
    // locked burst keeps H, otherwise the priority pointer decides.
    always_comb begin
        c_gnt_s      = 1'b0;
        h_gnt_s      = 1'b0;
        burst_hold_s = (state_r == ST_BURST) && (cnt_r < CNT_MAX) && h_lock;
        if (rst) begin
            c_gnt_s = 1'b0;
            h_gnt_s = 1'b0;
        end else if (c_req && !h_req) begin
            c_gnt_s = 1'b1;
        end else if (h_req && !c_req) begin
            h_gnt_s = 1'b1;
        end else if (c_req && h_req) begin
            if (burst_hold_s) begin
                h_gnt_s = 1'b1;
            end else if (prio_r == PRIO_C) begin
                c_gnt_s = 1'b1;
            end else begin
                h_gnt_s = 1'b1;
            end
        end else begin
            c_gnt_s = 1'b0;
            h_gnt_s = 1'b0;
        end
    end

    // Next FSM state, burst count and priority pointer, all derived from this cycle's grant
    always_comb begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = cnt_r;
        prio_nxt_s  = prio_r;
        if (c_gnt_s) begin
            state_nxt_s = ST_CPU;
            cnt_nxt_s   = CNT_ZERO;
            prio_nxt_s  = PRIO_H;
        end else if (h_gnt_s) begin
            prio_nxt_s = PRIO_C;
            if (h_lock) begin
                state_nxt_s = ST_BURST;
                // a fresh burst starts at 1; an uncontested burst past the
                // limit restarts its count so H can keep streaming
                if (state_r != ST_BURST) begin
                    cnt_nxt_s = CNT_ONE;
                end else if (cnt_r >= CNT_MAX) begin
                    cnt_nxt_s = CNT_ONE;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end else begin
                state_nxt_s = ST_HOST;
                cnt_nxt_s   = CNT_ZERO;
            end
        end else begin
            // no grant: go idle but remember fairness and burst history
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = cnt_r;
            prio_nxt_s  = prio_r;
        end
    end

    // FSM, burst counter and priority pointer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            prio_r  <= PRIO_RST;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            prio_r  <= prio_nxt_s;
        end
    end

    // Memory command register: launches the granted access, and keeps address/data stable when idle
    always_ff @(posedge clk) begin
        if (rst) begin
            d_addr_r  <= {AW{1'b0}};
            d_wr_r    <= 1'b0;
            d_wdata_r <= {DW{1'b0}};
        end else if (c_gnt_s) begin
            d_addr_r  <= c_addr;
            d_wr_r    <= c_wr;
            d_wdata_r <= c_wdata;
        end else if (h_gnt_s) begin
            d_addr_r  <= h_addr;
            d_wr_r    <= h_wr;
            d_wdata_r <= h_wdata;
        end else begin
            d_addr_r  <= d_addr_r;
            d_wr_r    <= 1'b0;
            d_wdata_r <= d_wdata_r;
        end
    end

    // Two-stage read tag pipe: grant -> command cycle -> data cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            c_rd_p1_r  <= 1'b0;
            h_rd_p1_r  <= 1'b0;
            c_rvalid_r <= 1'b0;
            h_rvalid_r <= 1'b0;
        end else begin
            c_rd_p1_r  <= c_gnt_s & ~c_wr;
            h_rd_p1_r  <= h_gnt_s & ~h_wr;
            c_rvalid_r <= c_rd_p1_r;
            h_rvalid_r <= h_rd_p1_r;
        end
    end

    assign c_gnt    = c_gnt_s;
    assign h_gnt    = h_gnt_s;
    assign c_rvalid = c_rvalid_r;
    assign h_rvalid = h_rvalid_r;
    assign rdata    = D_rdata;
    assign D_addr   = d_addr_r;
    assign D_wr     = d_wr_r;
    assign D_wdata  = d_wdata_r;
    assign State    = state_r;

    dmem_arbiter_chk #(
        .CW        (CW),
        .MAX_BURST (MAX_BURST)
    ) u_chk (
        .clk   (clk),
        .rst   (rst),
        .c_req (c_req),
        .h_req (h_req),
        .c_gnt (c_gnt_s),
        .h_gnt (h_gnt_s),
        .cnt   (cnt_r)
    );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: a behavioural 256x16 memory with 1-cycle
// read latency, scenario tasks with inline checks, and a read-data scoreboard.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        c_req, c_wr, c_gnt, c_rvalid;
    logic [7:0]  c_addr;
    logic [15:0] c_wdata;
    logic        h_req, h_wr, h_lock, h_gnt, h_rvalid;
    logic [7:0]  h_addr;
    logic [15:0] h_wdata;
    logic [15:0] rdata;
    logic [7:0]  D_addr;
    logic        D_wr;
    logic [15:0] D_wdata;
    logic [15:0] D_rdata;
    logic [1:0]  State;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic        port;   // 0 = C, 1 = H
        logic [15:0] data;
    } exp_t;
    exp_t sb_q[$];

    logic [15:0] mem [0:255];

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(8), .DW(16), .MAX_BURST(8), .CPU_FIRST(1)) dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_wr(c_wr), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid),
        .h_req(h_req), .h_wr(h_wr), .h_lock(h_lock), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_gnt(h_gnt), .h_rvalid(h_rvalid),
        .rdata(rdata), .D_addr(D_addr), .D_wr(D_wr), .D_wdata(D_wdata),
        .D_rdata(D_rdata), .State(State)
    );

    // behavioural single-port memory, read data one cycle after the address
    always @(posedge clk) begin
        if (D_wr) mem[D_addr] <= D_wdata;
        D_rdata <= mem[D_addr];
    end

    // scoreboard: every rvalid pops the oldest expected read
    always @(negedge clk) begin : sb_mon
        exp_t e;
        if (c_rvalid || h_rvalid) begin
            n_checks++;
            if (c_rvalid && h_rvalid) begin
                n_fail++; $display("FAIL rvalid_onehot: c_rvalid=1 h_rvalid=1, expected only one");
            end else if (sb_q.size() == 0) begin
                n_fail++; $display("FAIL rvalid_unexpected: c_rvalid=%0b h_rvalid=%0b rdata=%h, expected no read", c_rvalid, h_rvalid, rdata);
            end else begin
                e = sb_q.pop_front();
                if (h_rvalid !== e.port || rdata !== e.data) begin
                    n_fail++; $display("FAIL read_data: port=%0d rdata=%h, expected port=%0d rdata=%h", h_rvalid, rdata, e.port, e.data);
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        c_req = 1'b0; c_wr = 1'b0; c_addr = 8'h00; c_wdata = 16'h0000;
        h_req = 1'b0; h_wr = 1'b0; h_lock = 1'b0; h_addr = 8'h00; h_wdata = 16'h0000;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1; c_req = 1'b1; h_req = 1'b1; h_lock = 1'b1;
        @(negedge clk);
        n_checks++; if ({c_gnt, h_gnt} !== 2'b00) begin n_fail++; $display("FAIL reset_gnt: c/h=%b, expected 00", {c_gnt, h_gnt}); end
        n_checks++; if ({State, D_wr, D_addr, D_wdata} !== 27'd0) begin n_fail++; $display("FAIL reset_regs: State=%0d D_wr=%0b D_addr=%h D_wdata=%h, expected all 0", State, D_wr, D_addr, D_wdata); end
        n_checks++; if ({c_rvalid, h_rvalid} !== 2'b00) begin n_fail++; $display("FAIL reset_rvalid: c/h=%b, expected 00", {c_rvalid, h_rvalid}); end
        tick();
        idle_inputs();
        rst = 1'b0;
    endtask

    task automatic test_write_read();
        do_reset();
        c_req = 1'b1; c_wr = 1'b1; c_addr = 8'h10; c_wdata = 16'h1234;
        @(negedge clk);
        n_checks++; if ({c_gnt, h_gnt} !== 2'b10) begin n_fail++; $display("FAIL wr_gnt: c/h=%b, expected 10", {c_gnt, h_gnt}); end
        tick();
        c_wr = 1'b0;
        sb_q.push_back({1'b0, 16'h1234});
        @(negedge clk);
        n_checks++; if ({c_gnt, h_gnt} !== 2'b10) begin n_fail++; $display("FAIL rd_gnt: c/h=%b, expected 10", {c_gnt, h_gnt}); end
        n_checks++; if ({D_wr, D_addr, D_wdata} !== {1'b1, 8'h10, 16'h1234}) begin n_fail++; $display("FAIL wr_cmd: D_wr=%0b D_addr=%h D_wdata=%h, expected 1/10/1234", D_wr, D_addr, D_wdata); end
        tick();
        c_req = 1'b0;
        @(negedge clk);
        n_checks++; if ({D_wr, D_addr, c_rvalid} !== {1'b0, 8'h10, 1'b0}) begin n_fail++; $display("FAIL rd_cmd: D_wr=%0b D_addr=%h c_rvalid=%0b, expected 0/10/0", D_wr, D_addr, c_rvalid); end
        tick();
        @(negedge clk);
        n_checks++; if ({c_rvalid, h_rvalid, rdata} !== {2'b10, 16'h1234}) begin n_fail++; $display("FAIL rd_valid: c/h=%b rdata=%h, expected 10/1234", {c_rvalid, h_rvalid}, rdata); end
        tick();
        @(negedge clk);
        n_checks++; if ({c_rvalid, h_rvalid, D_wr, D_addr, State} !== {3'b000, 8'h10, 2'd0}) begin n_fail++; $display("FAIL rd_after: c/h=%b D_wr=%0b D_addr=%h State=%0d, expected 00/0/10/0", {c_rvalid, h_rvalid}, D_wr, D_addr, State); end
    endtask

    task automatic test_round_robin();
        logic exp_c;
        logic prev_c;
        prev_c = 1'b0;
        do_reset();
        c_req = 1'b1; c_wr = 1'b1; c_addr = 8'h20; c_wdata = 16'hC000;
        h_req = 1'b1; h_wr = 1'b1; h_addr = 8'h30; h_wdata = 16'hA000; h_lock = 1'b0;
        for (int i = 0; i < 6; i++) begin
            exp_c = (i % 2 == 0);
            @(negedge clk);
            n_checks++; if ({c_gnt, h_gnt} !== {exp_c, ~exp_c}) begin n_fail++; $display("FAIL rr_gnt[%0d]: c/h=%b, expected %b", i, {c_gnt, h_gnt}, {exp_c, ~exp_c}); end
            if (i > 0) begin
                n_checks++;
                if ({State, D_addr} !== {(prev_c ? 2'd1 : 2'd2), (prev_c ? 8'h20 : 8'h30)}) begin
                    n_fail++; $display("FAIL rr_state[%0d]: State=%0d D_addr=%h, expected %0d/%h", i, State, D_addr, (prev_c ? 2'd1 : 2'd2), (prev_c ? 8'h20 : 8'h30));
                end
            end
            prev_c = exp_c;
            tick();
        end
        idle_inputs();
        @(negedge clk);
        n_checks++; if (State !== 2'd2) begin n_fail++; $display("FAIL rr_last_state: State=%0d, expected 2", State); end
        tick();
    endtask

    task automatic test_burst();
        logic       exp_h [16];
        logic [7:0] c_n;
        logic [7:0] h_n;
        c_n = 8'h00;
        h_n = 8'h00;
        for (int k = 0; k < 16; k++) exp_h[k] = (k >= 1 && k <= 8) || (k >= 10 && k <= 13);
        do_reset();
        for (int k = 0; k < 16; k++) begin
            c_req = 1'b1; c_wr = 1'b1; c_addr = 8'h50 + c_n; c_wdata = 16'hC100 + {8'h00, c_n};
            h_req = (k > 0) && (h_n < 8'd12); h_lock = 1'b1; h_wr = 1'b1;
            h_addr = 8'h80 + h_n; h_wdata = 16'hB000 + {8'h00, h_n};
            @(negedge clk);
            n_checks++; if ({c_gnt, h_gnt} !== {~exp_h[k], exp_h[k]}) begin n_fail++; $display("FAIL burst_gnt[%0d]: c/h=%b, expected %b", k, {c_gnt, h_gnt}, {~exp_h[k], exp_h[k]}); end
            if (k > 0) begin
                n_checks++; if (State !== (exp_h[k-1] ? 2'd3 : 2'd1)) begin n_fail++; $display("FAIL burst_state[%0d]: State=%0d, expected %0d", k, State, (exp_h[k-1] ? 2'd3 : 2'd1)); end
            end
            if (exp_h[k]) h_n = h_n + 8'd1;
            else c_n = c_n + 8'd1;
            tick();
        end
        idle_inputs();
        @(negedge clk);
        n_checks++; if (State !== 2'd1) begin n_fail++; $display("FAIL burst_end_state: State=%0d, expected 1", State); end
        n_checks++; if (mem[8'h8B] !== 16'hB00B) begin n_fail++; $display("FAIL burst_last_write: mem[8B]=%h, expected B00B", mem[8'h8B]); end
        tick();
    endtask

    task automatic test_burst_wrap();
        do_reset();
        for (int k = 0; k < 17; k++) begin
            c_req = (k >= 10); c_wr = 1'b1; c_addr = 8'hA0; c_wdata = 16'hCAFE;
            h_req = (k < 16); h_lock = 1'b1; h_wr = 1'b1; h_addr = 8'h90 + 8'(k); h_wdata = 16'(k);
            @(negedge clk);
            n_checks++; if ({c_gnt, h_gnt} !== {(k >= 16), (k < 16)}) begin n_fail++; $display("FAIL wrap_gnt[%0d]: c/h=%b, expected %b", k, {c_gnt, h_gnt}, {(k >= 16), (k < 16)}); end
            if (k > 0) begin
                n_checks++; if (State !== 2'd3) begin n_fail++; $display("FAIL wrap_state[%0d]: State=%0d, expected 3", k, State); end
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_lock_drop();
        do_reset();
        c_req = 1'b1; c_wr = 1'b1; c_addr = 8'h70; c_wdata = 16'h7070;
        @(negedge clk);
        n_checks++; if ({c_gnt, h_gnt} !== 2'b10) begin n_fail++; $display("FAIL drop_first: c/h=%b, expected 10", {c_gnt, h_gnt}); end
        tick();
        c_addr = 8'h72;
        h_req = 1'b1; h_lock = 1'b1; h_wr = 1'b1; h_addr = 8'h71; h_wdata = 16'h7171;
        @(negedge clk);
        n_checks++; if ({c_gnt, h_gnt} !== 2'b01) begin n_fail++; $display("FAIL drop_h: c/h=%b, expected 01", {c_gnt, h_gnt}); end
        tick();
        h_lock = 1'b0; h_addr = 8'h73;
        @(negedge clk);
        n_checks++; if ({State, c_gnt, h_gnt} !== {2'd3, 2'b10}) begin n_fail++; $display("FAIL drop_rr: State=%0d c/h=%b, expected 3/10", State, {c_gnt, h_gnt}); end
        tick();
        idle_inputs();
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        c_req = 1'b1; c_wr = 1'b0; c_addr = 8'h10;
        @(negedge clk);
        n_checks++; if ({c_gnt, h_gnt} !== 2'b10) begin n_fail++; $display("FAIL mrst_gnt: c/h=%b, expected 10", {c_gnt, h_gnt}); end
        tick();
        idle_inputs();
        rst = 1'b1; c_req = 1'b1; h_req = 1'b1;
        @(negedge clk);
        n_checks++; if ({c_gnt, h_gnt} !== 2'b00) begin n_fail++; $display("FAIL mrst_gnt_in_rst: c/h=%b, expected 00", {c_gnt, h_gnt}); end
        tick();
        rst = 1'b0;
        c_req = 1'b1; c_wr = 1'b1; c_addr = 8'h60; c_wdata = 16'h5555;
        h_req = 1'b1; h_wr = 1'b1; h_addr = 8'h61; h_wdata = 16'h6666; h_lock = 1'b0;
        @(negedge clk);
        n_checks++; if ({c_rvalid, D_wr, State} !== {1'b0, 1'b0, 2'd0}) begin n_fail++; $display("FAIL mrst_state: c_rvalid=%0b D_wr=%0b State=%0d, expected 0/0/0", c_rvalid, D_wr, State); end
        n_checks++; if ({c_gnt, h_gnt} !== 2'b10) begin n_fail++; $display("FAIL mrst_prio: c/h=%b, expected 10", {c_gnt, h_gnt}); end
        tick();
        idle_inputs();
        @(negedge clk);
        n_checks++; if ({c_rvalid, D_wr, D_addr} !== {1'b0, 1'b1, 8'h60}) begin n_fail++; $display("FAIL mrst_after: c_rvalid=%0b D_wr=%0b D_addr=%h, expected 0/1/60", c_rvalid, D_wr, D_addr); end
        tick();
    endtask

    task automatic test_host_b2b();
        do_reset();
        h_req = 1'b1; h_wr = 1'b1; h_addr = 8'hFF; h_wdata = 16'hBEEF;
        @(negedge clk);
        n_checks++; if ({c_gnt, h_gnt} !== 2'b01) begin n_fail++; $display("FAIL hb_wr_gnt: c/h=%b, expected 01", {c_gnt, h_gnt}); end
        tick();
        h_wr = 1'b0;
        sb_q.push_back({1'b1, 16'hBEEF});
        @(negedge clk);
        n_checks++; if ({h_gnt, D_wr, D_addr, D_wdata} !== {2'b11, 8'hFF, 16'hBEEF}) begin n_fail++; $display("FAIL hb_wr_cmd: h_gnt=%0b D_wr=%0b D_addr=%h D_wdata=%h, expected 1/1/FF/BEEF", h_gnt, D_wr, D_addr, D_wdata); end
        tick();
        h_wr = 1'b1; h_addr = 8'h00; h_wdata = 16'h0A0A;
        @(negedge clk);
        n_checks++; if ({h_gnt, D_wr, D_addr} !== {2'b10, 8'hFF}) begin n_fail++; $display("FAIL hb_rd_cmd: h_gnt=%0b D_wr=%0b D_addr=%h, expected 1/0/FF", h_gnt, D_wr, D_addr); end
        tick();
        h_wr = 1'b0;
        sb_q.push_back({1'b1, 16'h0A0A});
        @(negedge clk);
        n_checks++; if ({c_rvalid, h_rvalid, rdata} !== {2'b01, 16'hBEEF}) begin n_fail++; $display("FAIL hb_rvalid: c/h=%b rdata=%h, expected 01/BEEF", {c_rvalid, h_rvalid}, rdata); end
        n_checks++; if ({D_wr, D_addr, D_wdata} !== {1'b1, 8'h00, 16'h0A0A}) begin n_fail++; $display("FAIL hb_addr0: D_wr=%0b D_addr=%h D_wdata=%h, expected 1/00/0A0A", D_wr, D_addr, D_wdata); end
        tick();
        idle_inputs();
        @(negedge clk);
        n_checks++; if ({h_rvalid, D_wr, D_addr} !== {2'b00, 8'h00}) begin n_fail++; $display("FAIL hb_gap: h_rvalid=%0b D_wr=%0b D_addr=%h, expected 0/0/00", h_rvalid, D_wr, D_addr); end
        tick();
        @(negedge clk);
        n_checks++; if ({h_rvalid, rdata} !== {1'b1, 16'h0A0A}) begin n_fail++; $display("FAIL hb_rd0: h_rvalid=%0b rdata=%h, expected 1/0A0A", h_rvalid, rdata); end
        tick();
    endtask

    task automatic test_lock_idle();
        do_reset();
        h_lock = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++; if ({c_gnt, h_gnt} !== 2'b00) begin n_fail++; $display("FAIL li_gnt[%0d]: c/h=%b, expected 00", i, {c_gnt, h_gnt}); end
            tick();
            @(negedge clk);
            n_checks++; if ({D_wr, State} !== {1'b0, 2'd0}) begin n_fail++; $display("FAIL li_state[%0d]: D_wr=%0b State=%0d, expected 0/0", i, D_wr, State); end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_round_robin();
        test_burst();
        test_burst_wrap();
        test_lock_drop();
        test_reset_mid_read();
        test_host_b2b();
        test_lock_idle();
        idle_inputs();
        repeat (4) tick();
        n_checks++; if (sb_q.size() != 0) begin n_fail++; $display("FAIL sb_drain: %0d reads outstanding, expected 0", sb_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
